// File: rtl/k_alu_pkg.sv
// Shared types and defaults for the K_ALU scheduler: FSM state encoding,
// default operand/select widths and a small one-hot helper.
package k_alu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester always wins, a tie goes to
// the requester named by prio, and next_prio points away from the winner.
module rr_arb2
  import k_alu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       next_prio
);

  logic w_win;

  always_comb begin
    w_win     = prio;
    grant     = 2'b00;
    next_prio = prio;
    if (req == 2'b01) begin
      w_win = 1'b0;
    end else if (req == 2'b10) begin
      w_win = 1'b1;
    end
    if (grant_en && (req != 2'b00)) begin
      grant     = onehot2(w_win);
      next_prio = ~w_win;
    end
  end

endmodule

// File: rtl/k_alu_sched.sv
// Shares one combinational K_ALU between two requesters: round-robin grant,
// registered operands to the ALU, result capture, per-requester response.
module k_alu_sched
  import k_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [SEL_W-1:0] req_sel0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [SEL_W-1:0] req_sel1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  state_t           r_state;
  logic             r_prio;
  logic             r_owner;
  logic             r_busy;
  logic [1:0]       r_rsp_valid_p2;
  logic [WIDTH-1:0] r_alu_a_p1;
  logic [WIDTH-1:0] r_alu_b_p1;
  logic [SEL_W-1:0] r_alu_sel_p1;
  logic [WIDTH-1:0] r_rsp_data_p2;

  logic [1:0]       w_grant;
  logic             w_next_prio;
  logic             w_grant_en;
  logic             w_rsp_accept;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign w_grant_en = (r_state == ST_IDLE) && rst_n;

  rr_arb2 u_arb (
    .req       (req_valid),
    .prio      (r_prio),
    .grant_en  (w_grant_en),
    .grant     (w_grant),
    .next_prio (w_next_prio)
  );

  // r_rsp_valid_p2 is one-hot on the owner, so the non-owner's ready drops out.
  assign w_rsp_accept = |(r_rsp_valid_p2 & rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_prio         <= 1'b0;
      r_owner        <= 1'b0;
      r_busy         <= 1'b0;
      r_rsp_valid_p2 <= 2'b00;
      r_alu_a_p1     <= '0;
      r_alu_b_p1     <= '0;
      r_alu_sel_p1   <= '0;
      r_rsp_data_p2  <= '0;
    end else begin
      case (r_state)
        // p1: operands of the granted requester drive the ALU
        ST_IDLE: begin
          if (w_grant != 2'b00) begin
            r_alu_a_p1   <= w_grant[1] ? req_a1   : req_a0;
            r_alu_b_p1   <= w_grant[1] ? req_b1   : req_b0;
            r_alu_sel_p1 <= w_grant[1] ? req_sel1 : req_sel0;
            r_owner      <= w_grant[1];
            r_prio       <= w_next_prio;
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        // p2: ALU result captured and offered to the owner
        ST_EXEC: begin
          r_rsp_data_p2  <= alu_res;
          r_rsp_valid_p2 <= onehot2(r_owner);
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_accept) begin
            r_rsp_valid_p2 <= 2'b00;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid_p2 <= 2'b00;
          r_busy         <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_grant;
  assign alu_a     = r_alu_a_p1;
  assign alu_b     = r_alu_b_p1;
  assign alu_sel   = r_alu_sel_p1;
  assign rsp_valid = r_rsp_valid_p2;
  assign rsp_data  = r_rsp_data_p2;
  assign rsp_zero  = (r_rsp_data_p2 == '0);
  assign busy      = r_busy;

endmodule

// File: tb/tb_k_alu_sched.sv
// Bench for k_alu_sched: a behavioural K_ALU closes the loop, directed
// scenarios plus a randomized run checked against a transaction-level model.
module tb_k_alu_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] req_sel0, req_sel1, alu_sel;
  logic [7:0] alu_a, alu_b, alu_res, rsp_data;
  logic       rsp_zero, busy;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] kalu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] s);
    logic [7:0] r;
    case (s)
      4'd0:    r = a + b;
      4'd1:    r = a & b;
      4'd2:    r = a - b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << 1;
      4'd6:    r = a >> 1;
      4'd7:    r = b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  assign alu_res = kalu(alu_a, alu_b, alu_sel);

  k_alu_sched #(.WIDTH(8), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [33:0] obs, exp;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    exp = {2'b00, 2'b00, 8'h00, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0};
    obs = {req_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel, busy};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, exp);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op;
    req_valid = 2'b01; req_a0 = 8'd6; req_b0 = 8'd4; req_sel0 = 4'd2;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    tick;
    req_valid = 2'b00;
    checks++;
    if ({alu_a, alu_b, alu_sel, rsp_valid, busy} !== {8'd6, 8'd4, 4'd2, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL single_exec: got a=%0d b=%0d sel=%0d rv=%b busy=%b expected 6 4 2 00 1",
               alu_a, alu_b, alu_sel, rsp_valid, busy);
    end
    tick;
    checks++;
    if ({rsp_valid, rsp_data, rsp_zero} !== {2'b01, kalu(8'd6, 8'd4, 4'd2), 1'b0}) begin
      errors++;
      $display("FAIL single_resp: got rv=%b data=%0d z=%b expected 01 %0d 0",
               rsp_valid, rsp_data, rsp_zero, kalu(8'd6, 8'd4, 4'd2));
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    checks++;
    if ({rsp_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL single_done: got rv=%b busy=%b expected 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp;
    do_reset;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_a0 = 8'd10; req_b0 = 8'd3; req_sel0 = 4'd0;
    req_a1 = 8'd20; req_b1 = 8'd5; req_sel1 = 4'd2;
    #1;
    for (int g = 0; g < 4; g++) begin
      int c = 0;
      while (req_ready == 2'b00 && c < 8) begin
        tick; c++;
      end
      exp = (g % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (req_ready !== exp) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp);
      end
      tick;
    end
    req_valid = 2'b00;
    repeat (3) tick;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d;
    exp_d = kalu(8'd200, 8'd100, 4'd0);
    req_valid = 2'b01; req_a0 = 8'd200; req_b0 = 8'd100; req_sel0 = 4'd0;
    tick;
    req_valid = 2'b00;
    tick;
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i % 2 == 0) ? 2'b10 : 2'b00;
      #1;
      checks++;
      if ({rsp_valid, rsp_data, alu_a, alu_b, alu_sel} !==
          {2'b01, exp_d, 8'd200, 8'd100, 4'd0}) begin
        errors++;
        $display("FAIL stall%0d: got rv=%b data=%0d a=%0d b=%0d sel=%0d expected 01 %0d 200 100 0",
                 i, rsp_valid, rsp_data, alu_a, alu_b, alu_sel, exp_d);
      end
      tick;
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    checks++;
    if ({rsp_valid, alu_a} !== {2'b00, 8'd200}) begin
      errors++; $display("FAIL stall_release: got rv=%b a=%0d expected 00 200", rsp_valid, alu_a);
    end
  endtask

  task automatic test_busy_blocking;
    req_valid = 2'b01; req_a0 = 8'd15; req_b0 = 8'd1; req_sel0 = 4'd4;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL block_grant0: got %b expected 01", req_ready);
    end
    tick;
    req_valid = 2'b10; req_a1 = 8'd33; req_b1 = 8'd2; req_sel1 = 4'd0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL block_exec: got %b expected 00", req_ready);
    end
    tick;
    rsp_ready = 2'b01;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data} !== {2'b00, 2'b01, kalu(8'd15, 8'd1, 4'd4)}) begin
      errors++;
      $display("FAIL block_resp: got rdy=%b rv=%b data=%0d expected 00 01 %0d",
               req_ready, rsp_valid, rsp_data, kalu(8'd15, 8'd1, 4'd4));
    end
    tick;
    rsp_ready = 2'b00;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== {2'b10, 2'b00}) begin
      errors++; $display("FAIL block_grant1: got rdy=%b rv=%b expected 10 00", req_ready, rsp_valid);
    end
    tick;
    req_valid = 2'b00;
    tick;
    checks++;
    if ({rsp_valid, rsp_data, alu_a} !== {2'b10, kalu(8'd33, 8'd2, 4'd0), 8'd33}) begin
      errors++;
      $display("FAIL block_resp1: got rv=%b data=%0d a=%0d expected 10 %0d 33",
               rsp_valid, rsp_data, alu_a, kalu(8'd33, 8'd2, 4'd0));
    end
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
  endtask

  task automatic test_zero_flag;
    logic [7:0] bs [2];
    bs[0] = 8'd77;
    bs[1] = 8'd76;
    for (int k = 0; k < 2; k++) begin
      req_valid = 2'b01; req_a0 = 8'd77; req_b0 = bs[k]; req_sel0 = 4'd2;
      tick;
      req_valid = 2'b00;
      tick;
      checks++;
      if ({rsp_data, rsp_zero} !== {kalu(8'd77, bs[k], 4'd2), (k == 0)}) begin
        errors++;
        $display("FAIL zero_flag%0d: got data=%0d z=%b expected %0d %b",
                 k, rsp_data, rsp_zero, kalu(8'd77, bs[k], 4'd2), (k == 0));
      end
      rsp_ready = 2'b01;
      tick;
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_reset_exec;
    logic [33:0] obs, exp;
    req_valid = 2'b01; req_a0 = 8'd5; req_b0 = 8'd7; req_sel0 = 4'd0;
    tick;
    req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    exp = {2'b00, 2'b00, 8'h00, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0};
    obs = {req_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel, busy};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_exec: got %h expected %h", obs, exp);
    end
    tick;
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({rsp_valid, busy} !== 3'b000) begin
        errors++; $display("FAIL post_reset%0d: got rv=%b busy=%b expected 00 0", i, rsp_valid, busy);
      end
    end
  endtask

  // Transaction-level model: at most one operation outstanding, grant follows
  // the round-robin rule, response appears two cycles after the grant.
  task automatic test_random;
    logic [1:0] pend, exp_rdy, exp_rv;
    logic [7:0] pa [2], pb [2];
    logic [3:0] ps [2];
    logic       m_prio, m_out, m_owner, win;
    int         m_age;
    logic [7:0] m_a, m_b, m_exp;
    logic [3:0] m_sel;
    do_reset;
    pend = 2'b00; m_prio = 1'b0; m_out = 1'b0; m_owner = 1'b0; m_age = 0;
    m_a = 8'd0; m_b = 8'd0; m_sel = 4'd0; m_exp = 8'd0;
    for (int i = 0; i < 2; i++) begin
      pa[i] = 8'd0; pb[i] = 8'd0; ps[i] = 4'd0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom); pb[i] = 8'($urandom); ps[i] = 4'($urandom);
        end
      end
      req_valid = pend;
      req_a0 = pa[0]; req_b0 = pb[0]; req_sel0 = ps[0];
      req_a1 = pa[1]; req_b1 = pb[1]; req_sel1 = ps[1];
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      exp_rdy = 2'b00;
      if (!m_out) begin
        if (pend == 2'b01) exp_rdy = 2'b01;
        else if (pend == 2'b10) exp_rdy = 2'b10;
        else if (pend == 2'b11) exp_rdy = m_prio ? 2'b10 : 2'b01;
      end
      exp_rv = (m_out && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({req_ready, rsp_valid} !== {exp_rdy, exp_rv}) begin
        errors++;
        $display("FAIL rnd_hs cyc%0d: got rdy=%b rv=%b expected rdy=%b rv=%b",
                 cyc, req_ready, rsp_valid, exp_rdy, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        checks++;
        if ({rsp_data, rsp_zero} !== {m_exp, (m_exp == 8'd0)}) begin
          errors++;
          $display("FAIL rnd_data cyc%0d: got data=%0d z=%b expected %0d %b",
                   cyc, rsp_data, rsp_zero, m_exp, (m_exp == 8'd0));
        end
      end
      if (m_out && m_age >= 1) begin
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {m_a, m_b, m_sel}) begin
          errors++;
          $display("FAIL rnd_alu cyc%0d: got %0d %0d %0d expected %0d %0d %0d",
                   cyc, alu_a, alu_b, alu_sel, m_a, m_b, m_sel);
        end
      end
      if (exp_rdy != 2'b00) begin
        win = exp_rdy[1];
        m_a = pa[win]; m_b = pb[win]; m_sel = ps[win];
        m_exp = kalu(m_a, m_b, m_sel);
        m_owner = win; m_prio = ~win; m_out = 1'b1; m_age = 0;
        pend[win] = 1'b0;
      end else if (exp_rv != 2'b00 && rsp_ready[m_owner]) begin
        m_out = 1'b0;
      end
      if (m_out) m_age++;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) tick;
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 8'd0; req_b0 = 8'd0; req_sel0 = 4'd0;
    req_a1 = 8'd0; req_b1 = 8'd0; req_sel1 = 4'd0;
    test_reset;
    test_single_op;
    test_simultaneous;
    test_backpressure;
    test_busy_blocking;
    test_zero_flag;
    test_reset_exec;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
